// File: rtl/riscv_lsu.sv
// ---------------------------------------------------------------------------
// riscv_lsu -- load/store unit between the multicycle core FSM and data memory
//
// Accepts one byte/half/word/double request at a time, checks alignment,
// drives one aligned memory access with byte enables and lane-replicated
// store data, waits for mem_ack, then returns sign/zero-extended load data.
// Misaligned or illegal-size requests are answered with resp_err and never
// reach memory.
//
// Handshakes:
//   core side : a request is taken on a rising edge with req_valid && req_ready;
//               req_ready is high only while idle. resp_valid is a one-cycle
//               pulse; resp_rdata/resp_err hold until the next pulse.
//   mem side  : mem_req and its qualifiers are held stable until a cycle with
//               mem_ack=1; mem_rdata is sampled in that same cycle.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata : request
//   resp_valid/resp_rdata/resp_err                                      : response
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata/mem_ack/mem_rdata           : memory
//   dbg_state : current FSM state (0=IDLE, 1=ACCESS, 2=RESP)
//
// Optional feature: define LSU_TIMEOUT_EN to abandon an access with resp_err
// after TIMEOUT cycles without mem_ack. Without it ACCESS waits indefinitely.
// ---------------------------------------------------------------------------
module riscv_lsu #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [1:0]            dbg_state
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    if (!(DATA_W == 32 || DATA_W == 64) || TIMEOUT < 1) begin : g_bad_param
        $error("riscv_lsu: DATA_W must be 32 or 64 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic               r_resp_valid;
    logic               r_resp_err;
    logic [DATA_W-1:0]  r_resp_rdata;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [NB-1:0]      r_mem_be;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_we;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic [OFF_W-1:0]   r_off;

    logic               w_err;
    logic [OFF_W-1:0]   w_off;
    logic [NB-1:0]      w_be;
    logic [DATA_W-1:0]  w_wrep;
    logic [DATA_W-1:0]  w_shift;
    logic [DATA_W-1:0]  w_load;
    logic               w_tmo_hit;

    assign w_off = req_addr[OFF_W-1:0];

    // Alignment / legal-size check on the incoming request.
    always_comb begin
        w_err = 1'b0;
        case (req_size)
            2'd1:    w_err = req_addr[0];
            2'd2:    w_err = |req_addr[1:0];
            2'd3:    w_err = (DATA_W == 32) || (|req_addr[2:0]);
            default: w_err = 1'b0;
        endcase
    end

    // Byte enables: one bit per accessed byte, starting at the lane offset.
    // Store data: lane i takes byte (i mod access-size) of the right-aligned data.
    always_comb begin
        int nb;
        nb     = 1 << req_size;
        w_be   = '0;
        w_wrep = '0;
        for (int i = 0; i < NB; i++) begin
            w_be[i] = (i >= int'(w_off)) && (i < int'(w_off) + nb);
            w_wrep[8*i +: 8] = req_wdata[8*(i % nb) +: 8];
        end
    end

    // Load path: bring the addressed lanes down to bit 0, then extend.
    assign w_shift = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        int nbits;
        int sidx;
        nbits  = 8 << r_size;
        sidx   = (nbits > DATA_W) ? DATA_W - 1 : nbits - 1;
        w_load = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_load[i] = (i < nbits) ? w_shift[i] : (!r_unsigned && w_shift[sidx]);
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] r_tmo;

    // Counts ACCESS cycles without mem_ack; held at zero outside ACCESS so it
    // is clear on every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo <= '0;
        end else if (r_state != S_ACCESS) begin
            r_tmo <= '0;
        end else if (!mem_ack) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // The current cycle is the TIMEOUT-th without acknowledge.
    assign w_tmo_hit = (r_tmo == CW'(TIMEOUT - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_off        <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_ready    <= 1'b0;
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_off      <= w_off;
                        if (w_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state     <= S_ACCESS;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= req_we;
                            r_mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wrep;
                        end
                    end
                end
                S_ACCESS: begin
                    // An acknowledge in the limit cycle takes priority.
                    if (mem_ack) begin
                        r_state      <= S_RESP;
                        r_mem_req    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_we ? '0 : w_load;
                    end else if (w_tmo_hit) begin
                        r_state      <= S_RESP;
                        r_mem_req    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_riscv_lsu.sv
// ---------------------------------------------------------------------------
// tb_riscv_lsu -- directed and randomized checks of riscv_lsu (DATA_W=32).
// Expected values come from a byte-level reference model: address/enables
// from size and offset arithmetic, load data by shift/mask/extend.
// ---------------------------------------------------------------------------
module tb_riscv_lsu;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int TB_TMO = 4;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic            resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic            resp_err;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;
    logic [1:0]      dbg_state;

    riscv_lsu #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TB_TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] ref_load(input logic [1:0] size, input logic uns,
                                                input int off, input logic [DW-1:0] rd);
        logic [63:0] m;
        logic [63:0] v;
        int nb;
        nb = 1 << size;
        m  = (64'd1 << (8 * nb)) - 64'd1;
        v  = (64'(rd) >> (8 * off)) & m;
        if (!uns && v[8*nb-1]) v = v | ~m;
        return v[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] ref_wrep(input logic [1:0] size, input logic [DW-1:0] wd);
        logic [63:0] m;
        logic [63:0] v;
        logic [63:0] r;
        int nb;
        nb = 1 << size;
        m  = (64'd1 << (8 * nb)) - 64'd1;
        v  = 64'(wd) & m;
        r  = 64'd0;
        for (int k = 0; k < 4 / nb; k++) r = r | (v << (8 * nb * k));
        return r[DW-1:0];
    endfunction

    // ---------------- driver ----------------
    // One complete request. The memory model acknowledges in ACCESS cycle
    // waits+1; a waits value past the timeout limit means "never acknowledge".
    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int waits);
        int nb, off, cyc, acc, resp_cyc, exp_acc;
        logic err, tmo;
        logic [DW-1:0] exp_rd;
        logic [3:0] exp_be;
        nb  = 1 << size;
        off = int'(addr[1:0]);
        err = (size == 2'd3) || ((addr % nb) != 0);
`ifdef LSU_TIMEOUT_EN
        tmo = !err && (waits + 1 > TB_TMO);
`else
        tmo = 1'b0;
`endif
        exp_acc = err ? 0 : (tmo ? TB_TMO : waits + 1);
        exp_be  = 4'(((1 << nb) - 1) << off);
        exp_rd  = (err || tmo || we) ? '0 : ref_load(size, uns, off, rd);
        exp_q.push_back(exp_rd);

        chk({tag, "_ready_before"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = $urandom();
        acc = 0; resp_cyc = 0; cyc = 0;
        while (resp_cyc == 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mem_req) begin
                acc++;
                chk({tag, "_mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
                chk({tag, "_mem_be"}, mem_be, exp_be);
                if (acc == 1) begin
                    chk({tag, "_mem_we"}, mem_we, we);
                    if (we) chk({tag, "_mem_wdata"}, mem_wdata, ref_wrep(size, wd));
                end
                mem_ack   = (acc == waits + 1);
                mem_rdata = mem_ack ? rd : $urandom();
            end else begin
                mem_ack = 1'b0;
            end
            if (resp_valid) begin
                resp_cyc = cyc;
                chk({tag, "_rdata"}, resp_rdata, exp_q.pop_front());
                chk({tag, "_err"}, resp_err, err || tmo);
            end
        end
        mem_ack = 1'b0;
        chk({tag, "_resp_seen"}, resp_cyc != 0, 1);
        chk({tag, "_latency"}, resp_cyc, exp_acc + 1);
        chk({tag, "_mem_req_cycles"}, acc, exp_acc);
        @(negedge clk);
        chk({tag, "_pulse_one_cycle"}, resp_valid, 0);
        chk({tag, "_ready_after"}, req_ready, 1);
        chk({tag, "_rdata_hold"}, resp_rdata, exp_rd);
    endtask

    task automatic stray_ack(input string tag);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ack = 1'b1;
            mem_rdata = $urandom();
            chk({tag, "_no_resp"}, resp_valid, 0);
            chk({tag, "_no_mem_req"}, mem_req, 0);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        chk({tag, "_no_resp_end"}, resp_valid, 0);
        chk({tag, "_ready"}, req_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_req("lw_100",   1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        run_req("lb_103",   1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80123456, 0);
        run_req("lbu_103",  1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80123456, 1);
        run_req("sh_102",   1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 32'h0, 3);
        run_req("lw_101",   1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h12345678, 0);
        run_req("ld_100",   1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h12345678, 0);
        run_req("lh_101",   1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h12345678, 0);
        run_req("lhu_102",  1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'hF00D1234, 2);
        run_req("lh_102",   1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'hF00D1234, 0);
        run_req("sb_101",   1'b1, 2'd0, 1'b0, 32'h101, 32'hFFFFFF5A, 32'h0, 1);
        stray_ack("stray_idle");

`ifdef LSU_TIMEOUT_EN
        run_req("lw_tmo",   1'b0, 2'd2, 1'b0, 32'h180, 32'h0, 32'h11111111, 50);
        stray_ack("stray_after_tmo");
        run_req("lw_ack_at_limit", 1'b0, 2'd2, 1'b0, 32'h184, 32'h0, 32'h22222222, TB_TMO - 1);
`endif

        // Reset in the middle of an access.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h200;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_pre_mem_req", mem_req, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_ready", req_ready, 1);
        @(negedge clk);
        chk("rst_mid_resp_valid2", resp_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rel_resp_valid", resp_valid, 0);
        chk("rst_rel_ready", req_ready, 1);
        chk("rst_rel_mem_req", mem_req, 0);
        run_req("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 32'hCAFEF00D, 0);

        // Randomized requests, mostly aligned.
        for (int n = 0; n < 40; n++) begin
            logic [1:0] sz;
            int nb, off;
            logic [31:0] base;
            sz   = 2'($urandom_range(0, 3));
            nb   = 1 << sz;
            base = $urandom() & 32'hFFFF_FFF0;
            if ($urandom_range(0, 3) == 0) off = $urandom_range(0, 3);
            else if (nb >= 4)              off = 0;
            else                           off = ($urandom_range(0, 3) / nb) * nb;
            run_req("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                    base | 32'(off), $urandom(), $urandom(), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Parametrised load/store unit between the multicycle RISC-V core FSM and a data memory that may insert wait states. It accepts one request at a time: byte, half, word or (when DATA_W=64) double. It generates aligned addresses, byte enables and lane-replicated write data, waits for a memory acknowledge, then returns sign- or zero-extended load data. Misaligned requests are rejected without touching memory.

Parameters:
ADDR_W, 32, byte-address width.
DATA_W, 32, memory/bus data width; legal values 32 or 64.
TIMEOUT, 255, maximum ACCESS cycles without mem_ack; used only when LSU_TIMEOUT_EN is defined.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-low reset.
req_valid  input  1  core request strobe.
req_ready  output  1  unit can accept a request.
req_we  input  1  1=store, 0=load.
req_size  input  2  0=byte, 1=half, 2=word, 3=double.
req_unsigned  input  1  zero-extend load (LBU/LHU/LWU).
req_addr  input  ADDR_W  byte address.
req_wdata  input  DATA_W  store data, right-aligned.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  DATA_W  extended load data; 0 for stores and errors.
resp_err  output  1  qualifies resp_valid: misaligned, illegal size, or timeout.
mem_req  output  1  memory access strobe, held until mem_ack.
mem_we  output  1  memory write enable.
mem_addr  output  ADDR_W  req_addr with low log2(DATA_W/8) bits cleared.
mem_be  output  DATA_W/8  byte-lane enables.
mem_wdata  output  DATA_W  store data replicated across all lanes.
mem_ack  input  1  memory done; mem_rdata is valid in the same cycle.
mem_rdata  input  DATA_W  memory read data.

Behaviour:
- States: IDLE, ACCESS, RESP. Reset (rst=0) forces IDLE immediately and asynchronously. Outputs during reset: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- req_ready=1 only in IDLE. Accept = req_valid && req_ready at a rising edge. On accept, all request fields are latched into internal registers.
- Alignment check at accept. A request is an error when any of these holds:
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - double with addr[2:0]!=0
  - size=3 when DATA_W=32
- Error path: accept -> RESP. No mem_req is issued. resp_err=1, resp_rdata=0.
- Legal path: accept -> ACCESS.
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered and stable for the whole of ACCESS.
  - mem_be = size mask (1, 3, F or FF) shifted left by the address offset within the bus word.
- ACCESS and mem_ack=1 -> RESP.
  - Loads: the selected lanes are shifted down, then sign-extended (req_unsigned=0) or zero-extended (req_unsigned=1) to DATA_W, and registered into resp_rdata.
  - Stores: resp_rdata=0.
- ACCESS and mem_ack=0: remain in ACCESS.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_err hold until the next resp_valid.
- Latency, zero-wait memory:
  - Accept edge ends cycle N. mem_req is high in cycle N+1 and resp_valid is high in N+2.
  - Each wait cycle adds 1.
  - Error responses: resp_valid in N+1.
  - Next accept is possible at the end of the resp_valid cycle + 1 (IDLE).
- mem_ack is ignored outside ACCESS.
- A reset asserted mid-ACCESS drops mem_req the same cycle. No response is generated.

Optional Feature:
Macro LSU_TIMEOUT_EN.
- Defined: an 8+ bit counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ack. If it reaches TIMEOUT, the unit leaves ACCESS: mem_req drops and state goes to RESP with resp_err=1, resp_rdata=0. A mem_ack in the same cycle as the limit wins and completes normally.
- Undefined: no counter is built. ACCESS waits indefinitely and TIMEOUT is unused.

Test Plan:
- LW, addr 0x100, ack in first ACCESS cycle, mem_rdata 0xDEADBEEF -> mem_addr 0x100, mem_be 4'b1111, resp_valid at N+2, resp_rdata 0xDEADBEEF, resp_err 0.
- LB addr 0x103, mem_rdata 0x80123456 -> mem_be 4'b1000, resp_rdata 0xFFFFFF80; same with req_unsigned=1 -> 0x00000080.
- SH addr 0x102, req_wdata 0x0000ABCD, ack after 3 wait cycles -> mem_be 4'b1100, mem_wdata 0xABCDABCD, mem_we 1; mem_req high 4 cycles, resp_valid at N+5, resp_rdata 0.
- LW addr 0x101 -> mem_req never asserted, resp_valid at N+1 with resp_err 1; size=3 with DATA_W=32 gives the same result.
- LSU_TIMEOUT_EN, TIMEOUT=4, mem_ack held 0 -> mem_req high N+1..N+4, resp_valid with resp_err 1 at N+5; a later stray mem_ack in IDLE causes no response.
- rst driven low during ACCESS -> mem_req 0 immediately, no resp_valid; after release req_ready=1, and a new LW completes normally.
